// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches 1- or 2-byte instructions from a 1-cycle synchronous ROM
// and presents them over valid/ready. Optional macro IFU_PERF_CNT_EN adds instr_count.
module instr_fetch_unit #(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [DATA_W-1:0] IMM_OPCODE  = 8'h1F,
    parameter logic [DATA_W-1:0] HALT_OPCODE = 8'h20
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] instr_opcode,
    output logic [DATA_W-1:0] instr_imm,
    output logic              instr_has_imm,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted,
`ifdef IFU_PERF_CNT_EN
    output logic [15:0]       instr_count,
`endif
    output logic [2:0]        dbg_state
);

    // Handshake: an instruction transfers on a rising edge with out_valid && out_ready.
    // While out_valid is high the instr_* outputs are stable; only jump_en or reset drops it early.
    typedef enum logic [2:0] {
        S_FETCH_OP  = 3'd0,
        S_LATCH_OP  = 3'd1,
        S_FETCH_IMM = 3'd2,
        S_LATCH_IMM = 3'd3,
        S_PRESENT   = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t              r_state,     w_state;
    logic [ADDR_W-1:0]   r_pc,        w_pc;
    logic                r_out_valid, w_out_valid;
    logic [DATA_W-1:0]   r_opcode,    w_opcode;
    logic [DATA_W-1:0]   r_imm,       w_imm;
    logic                r_has_imm,   w_has_imm;
    logic [ADDR_W-1:0]   r_instr_pc,  w_instr_pc;
    logic                r_halted,    w_halted;
    logic                w_hs;

    assign w_hs = r_out_valid && out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_FETCH_OP;
            r_pc        <= RESET_PC;
            r_out_valid <= 1'b0;
            r_opcode    <= '0;
            r_imm       <= '0;
            r_has_imm   <= 1'b0;
            r_instr_pc  <= '0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_pc        <= w_pc;
            r_out_valid <= w_out_valid;
            r_opcode    <= w_opcode;
            r_imm       <= w_imm;
            r_has_imm   <= w_has_imm;
            r_instr_pc  <= w_instr_pc;
            r_halted    <= w_halted;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_pc        = r_pc;
        w_out_valid = r_out_valid;
        w_opcode    = r_opcode;
        w_imm       = r_imm;
        w_has_imm   = r_has_imm;
        w_instr_pc  = r_instr_pc;
        w_halted    = r_halted;
        // A redirect overrides everything, including a coincident halt handshake.
        if (jump_en) begin
            w_state     = S_FETCH_OP;
            w_pc        = jump_target;
            w_out_valid = 1'b0;
            w_halted    = 1'b0;
        end else begin
            case (r_state)
                S_FETCH_OP: w_state = S_LATCH_OP;
                S_LATCH_OP: begin
                    w_opcode   = rom_q;
                    w_instr_pc = r_pc;
                    w_pc       = r_pc + ADDR_W'(1);
                    if (rom_q == IMM_OPCODE) begin
                        w_state = S_FETCH_IMM;
                    end else begin
                        w_imm       = '0;
                        w_has_imm   = 1'b0;
                        w_state     = S_PRESENT;
                        w_out_valid = 1'b1;
                    end
                end
                S_FETCH_IMM: w_state = S_LATCH_IMM;
                S_LATCH_IMM: begin
                    w_imm       = rom_q;
                    w_has_imm   = 1'b1;
                    w_pc        = r_pc + ADDR_W'(1);
                    w_state     = S_PRESENT;
                    w_out_valid = 1'b1;
                end
                S_PRESENT: begin
                    if (w_hs) begin
                        w_out_valid = 1'b0;
                        if (r_opcode == HALT_OPCODE) begin
                            w_state  = S_HALT;
                            w_halted = 1'b1;
                        end else begin
                            w_state = S_FETCH_OP;
                        end
                    end
                end
                S_HALT:  w_state = S_HALT;
                default: w_state = S_FETCH_OP;
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [15:0] r_instr_count;

    // Saturating count of accepted instructions; survives redirects.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_instr_count <= '0;
        end else if (w_hs && (r_instr_count != 16'hFFFF)) begin
            r_instr_count <= r_instr_count + 16'd1;
        end
    end

    assign instr_count = r_instr_count;
`endif

    assign rom_addr      = r_pc;
    assign out_valid     = r_out_valid;
    assign instr_opcode  = r_opcode;
    assign instr_imm     = r_imm;
    assign instr_has_imm = r_has_imm;
    assign instr_pc      = r_instr_pc;
    assign halted        = r_halted;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized run
// checked against an instruction-level model of the program stream.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rom_addr;
  logic [7:0] rom_q = 8'h00;
  logic       jump_en = 1'b0;
  logic [7:0] jump_target = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] instr_opcode;
  logic [7:0] instr_imm;
  logic       instr_has_imm;
  logic [7:0] instr_pc;
  logic       halted;
  logic [2:0] dbg_state;
`ifdef IFU_PERF_CNT_EN
  logic [15:0] instr_count;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  logic [7:0]  rom_mem [256];
  logic [24:0] exp_q [$];

  instr_fetch_unit dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rom_addr      (rom_addr),
    .rom_q         (rom_q),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .instr_opcode  (instr_opcode),
    .instr_imm     (instr_imm),
    .instr_has_imm (instr_has_imm),
    .instr_pc      (instr_pc),
    .halted        (halted),
`ifdef IFU_PERF_CNT_EN
    .instr_count   (instr_count),
`endif
    .dbg_state     (dbg_state)
  );

  // clock / reset / ROM environment
  always #5 clock = ~clock;

  always @(posedge clock) rom_q <= rom_mem[rom_addr];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) hs_cnt <= 0;
    else if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // driver tasks (called at a negedge)
  task automatic pulse_jump(input logic [7:0] tgt);
    jump_en = 1'b1;
    jump_target = tgt;
    @(negedge clock);
    jump_en = 1'b0;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    out_ready = 1'b0;
    jump_en = 1'b0;
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'h00;
    #3;
    n_cmp++;
    if ({out_valid, halted, rom_addr, instr_opcode, instr_imm, instr_has_imm, instr_pc} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b h=%b addr=%h op=%h imm=%h has=%b pc=%h want all zero",
               out_valid, halted, rom_addr, instr_opcode, instr_imm, instr_has_imm, instr_pc);
    end
`ifdef IFU_PERF_CNT_EN
    n_cmp++;
    if (instr_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_count: got %h want 0000", instr_count);
    end
`endif
  endtask

  task automatic test_single_byte();
    rom_mem[0] = 8'h06;
    rom_mem[1] = 8'h0B;
    out_ready = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL early_valid_edge1: got %b want 0", out_valid);
    end
    @(negedge clock);
    n_cmp++;
    if ({out_valid, instr_opcode, instr_pc, instr_has_imm, instr_imm} !== {1'b1, 8'h06, 8'h00, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL first_instr: got v=%b op=%h pc=%h has=%b imm=%h want 1 06 00 0 00",
               out_valid, instr_opcode, instr_pc, instr_has_imm, instr_imm);
    end
    @(negedge clock);
    @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_valid_edge4: got %b want 0", out_valid);
    end
    @(negedge clock);
    n_cmp++;
    if ({out_valid, instr_opcode, instr_pc, instr_has_imm} !== {1'b1, 8'h0B, 8'h01, 1'b0}) begin
      n_fail++;
      $display("FAIL second_instr: got v=%b op=%h pc=%h has=%b want 1 0B 01 0",
               out_valid, instr_opcode, instr_pc, instr_has_imm);
    end
  endtask

  task automatic test_imm();
    bit bad = 1'b0;
    rom_mem[4] = 8'h1F;
    rom_mem[5] = 8'hFE;
    out_ready = 1'b1;
    pulse_jump(8'h04);
    repeat (3) begin
      @(negedge clock);
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL imm_latency: got out_valid before edge 4 want low for edges 1..3");
    end
    @(negedge clock);
    n_cmp++;
    if ({out_valid, instr_opcode, instr_pc, instr_has_imm, instr_imm} !== {1'b1, 8'h1F, 8'h04, 1'b1, 8'hFE}) begin
      n_fail++;
      $display("FAIL imm_instr: got v=%b op=%h pc=%h has=%b imm=%h want 1 1F 04 1 FE",
               out_valid, instr_opcode, instr_pc, instr_has_imm, instr_imm);
    end
    @(negedge clock);
    n_cmp++;
    if ({out_valid, rom_addr} !== {1'b0, 8'h06}) begin
      n_fail++;
      $display("FAIL imm_next_fetch: got v=%b addr=%h want 0 06", out_valid, rom_addr);
    end
  endtask

  task automatic test_stall();
    bit ok;
    rom_mem[8'h40] = 8'h1F;
    rom_mem[8'h41] = 8'h77;
    rom_mem[8'h42] = 8'h05;
    out_ready = 1'b0;
    pulse_jump(8'h40);
    wait_valid(8, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stall_wait: got no out_valid within 8 cycles want valid");
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if ({out_valid, instr_opcode, instr_pc, instr_has_imm, instr_imm, rom_addr} !==
          {1'b1, 8'h1F, 8'h40, 1'b1, 8'h77, 8'h42}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b op=%h pc=%h has=%b imm=%h addr=%h want 1 1F 40 1 77 42",
                 i, out_valid, instr_opcode, instr_pc, instr_has_imm, instr_imm, rom_addr);
      end
      if (i < 5) @(negedge clock);
    end
    out_ready = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({out_valid, rom_addr} !== {1'b0, 8'h42}) begin
      n_fail++;
      $display("FAIL stall_release: got v=%b addr=%h want 0 42", out_valid, rom_addr);
    end
    wait_valid(8, ok);
    n_cmp++;
    if (!ok || {instr_opcode, instr_pc} !== {8'h05, 8'h42}) begin
      n_fail++;
      $display("FAIL stall_next: got ok=%b op=%h pc=%h want 1 05 42", ok, instr_opcode, instr_pc);
    end
  endtask

  task automatic test_halt();
    bit ok;
    bit bad = 1'b0;
    rom_mem[8'h98] = 8'h20;
    rom_mem[8'h00] = 8'h06;
    out_ready = 1'b1;
    pulse_jump(8'h98);
    wait_valid(8, ok);
    n_cmp++;
    if (!ok || {instr_opcode, instr_pc} !== {8'h20, 8'h98}) begin
      n_fail++;
      $display("FAIL halt_instr: got ok=%b op=%h pc=%h want 1 20 98", ok, instr_opcode, instr_pc);
    end
    repeat (9) begin
      @(negedge clock);
      if ({halted, out_valid, rom_addr} !== {1'b1, 1'b0, 8'h99}) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL halt_hold: got h=%b v=%b addr=%h want 1 0 99", halted, out_valid, rom_addr);
    end
    pulse_jump(8'h00);
    n_cmp++;
    if (halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_release: got halted=%b want 0", halted);
    end
    wait_valid(8, ok);
    n_cmp++;
    if (!ok || {instr_opcode, instr_pc} !== {8'h06, 8'h00}) begin
      n_fail++;
      $display("FAIL halt_resume: got ok=%b op=%h pc=%h want 1 06 00", ok, instr_opcode, instr_pc);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    rom_mem[8'hFF] = 8'h1F;
    rom_mem[8'h00] = 8'h0A;
    rom_mem[8'h01] = 8'h00;
    out_ready = 1'b1;
    pulse_jump(8'hFF);
    wait_valid(8, ok);
    n_cmp++;
    if (!ok || {instr_opcode, instr_pc, instr_has_imm, instr_imm} !== {8'h1F, 8'hFF, 1'b1, 8'h0A}) begin
      n_fail++;
      $display("FAIL wrap_instr: got ok=%b op=%h pc=%h has=%b imm=%h want 1 1F FF 1 0A",
               ok, instr_opcode, instr_pc, instr_has_imm, instr_imm);
    end
    @(negedge clock);
    n_cmp++;
    if ({out_valid, rom_addr} !== {1'b0, 8'h01}) begin
      n_fail++;
      $display("FAIL wrap_next_fetch: got v=%b addr=%h want 0 01", out_valid, rom_addr);
    end
  endtask

  // Model: the program is a byte stream; each accepted instruction starts at exp_pc and
  // spans 1 or 2 bytes, a redirect restarts the stream, a consumed halt stops it.
  task automatic test_random();
    logic [7:0]  exp_pc;
    logic [7:0]  op, imm, tgt;
    logic [24:0] exp;
    bit          has, rdy, jmp, m_halted;
    int          gap;
    int          r;
    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(0, 15);
      rom_mem[i] = (r == 0) ? 8'h1F : (r == 1) ? 8'h20 : 8'($urandom_range(0, 255));
    end
    out_ready = 1'b0;
    pulse_jump(8'h00);
    exp_pc = 8'h00;
    m_halted = 1'b0;
    gap = 0;
    repeat (3000) begin
      rdy = ($urandom_range(0, 3) != 0);
      jmp = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      tgt = 8'($urandom_range(0, 255));
      out_ready = rdy;
      jump_en = jmp;
      jump_target = tgt;
      n_cmp++;
      if (halted !== m_halted || (m_halted && out_valid !== 1'b0)) begin
        n_fail++;
        $display("FAIL rand_halt: got h=%b v=%b want h=%b v=0", halted, out_valid, m_halted);
      end
      if (out_valid === 1'b1 && rdy) begin
        op = rom_mem[exp_pc];
        has = (op == 8'h1F);
        imm = has ? rom_mem[8'(exp_pc + 8'd1)] : 8'h00;
        exp_q.push_back({exp_pc, op, has, imm});
        exp = exp_q.pop_front();
        n_cmp++;
        if ({instr_pc, instr_opcode, instr_has_imm, instr_imm} !== exp) begin
          n_fail++;
          $display("FAIL rand_instr: got pc=%h op=%h has=%b imm=%h want pc=%h op=%h has=%b imm=%h",
                   instr_pc, instr_opcode, instr_has_imm, instr_imm,
                   exp[24:17], exp[16:9], exp[8], exp[7:0]);
        end
        exp_pc = has ? 8'(exp_pc + 8'd2) : 8'(exp_pc + 8'd1);
        if (op == 8'h20 && !jmp) m_halted = 1'b1;
      end
      if (out_valid !== 1'b1 && !m_halted) gap++;
      else gap = 0;
      if (gap > 4) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rand_latency: got %0d cycles without out_valid want at most 4", gap);
        gap = 0;
      end
      if (jmp) begin
        exp_pc = tgt;
        m_halted = 1'b0;
        gap = 0;
      end
      @(negedge clock);
    end
    jump_en = 1'b0;
    out_ready = 1'b0;
`ifdef IFU_PERF_CNT_EN
    n_cmp++;
    if (instr_count !== 16'(hs_cnt)) begin
      n_fail++;
      $display("FAIL rand_count: got %0d want %0d", instr_count, hs_cnt);
    end
`endif
  endtask

  task automatic test_jump_partial_reset();
    bit bad = 1'b0;
    rom_mem[8'h10] = 8'h1F;
    rom_mem[8'h11] = 8'h55;
    rom_mem[8'h20] = 8'h33;
    out_ready = 1'b0;
    pulse_jump(8'h10);
    repeat (3) begin
      @(negedge clock);
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    pulse_jump(8'h20);
    if (out_valid !== 1'b0) bad = 1'b1;
    @(negedge clock);
    if (out_valid !== 1'b0) bad = 1'b1;
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL partial_dropped: got out_valid for discarded instruction want 0");
    end
    @(negedge clock);
    n_cmp++;
    if ({out_valid, instr_opcode, instr_pc, instr_has_imm, instr_imm} !== {1'b1, 8'h33, 8'h20, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL jump_target_instr: got v=%b op=%h pc=%h has=%b imm=%h want 1 33 20 0 00",
               out_valid, instr_opcode, instr_pc, instr_has_imm, instr_imm);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, halted, rom_addr, instr_opcode, instr_imm, instr_has_imm, instr_pc} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b h=%b addr=%h op=%h imm=%h has=%b pc=%h want all zero",
               out_valid, halted, rom_addr, instr_opcode, instr_imm, instr_has_imm, instr_pc);
    end
`ifdef IFU_PERF_CNT_EN
    n_cmp++;
    if (instr_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset_count: got %h want 0000", instr_count);
    end
`endif
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_imm();
    test_stall();
    test_halt();
    test_wrap();
    test_random();
    test_jump_partial_reset();
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
